// File: rtl/pic_host_sequencer_if.sv
// Signal bundle between the host sequencer and the PIC pins / core side.
// master = sequencer, slave = PIC plus core.
interface pic_host_sequencer_if;
   logic       chip_select_n;
   logic       write_enable_n;
   logic [7:0] address;
   logic [7:0] data_bus_out;
   logic [7:0] data_bus_in;
   logic       interrupt_to_cpu;
   logic       interrupt_acknowledge_n;
   logic       init_done;
   logic       vector_valid;
   logic [7:0] vector_data;
   logic       vector_ready;
   logic       eoi_request;
   logic       busy;

   modport master (
      output chip_select_n, write_enable_n, address, data_bus_out,
      output interrupt_acknowledge_n, init_done, vector_valid, vector_data, busy,
      input  data_bus_in, interrupt_to_cpu, vector_ready, eoi_request
   );

   modport slave (
      input  chip_select_n, write_enable_n, address, data_bus_out,
      input  interrupt_acknowledge_n, init_done, vector_valid, vector_data, busy,
      output data_bus_in, interrupt_to_cpu, vector_ready, eoi_request
   );
endinterface

// File: rtl/pic_host_sequencer.sv
// Host-side bus sequencer for an 8259A: programs it after reset, runs the
// two-pulse INTA cycle to fetch vectors and issues non-specific EOIs.
module pic_host_sequencer #(
   parameter logic [7:0] ICW1         = 8'h13,
   parameter logic [7:0] ICW2         = 8'h20,
   parameter logic [7:0] ICW3         = 8'h00,
   parameter logic [7:0] ICW4         = 8'h01,
   parameter logic [7:0] OCW1_MASK    = 8'hFE,
   parameter int         PULSE_CYCLES = 2,
   parameter int         GAP_CYCLES   = 1
) (
   input logic                  clock,
   input logic                  reset_n,
   pic_host_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_INIT, S_WR_SETUP, S_WR_STROBE, S_WR_HOLD, S_WR_GAP,
      S_IDLE, S_INTA1, S_INTA_GAP, S_INTA2, S_VEC_HOLD
   } state_t;

   typedef struct packed {
      logic       a0;
      logic [7:0] data;
   } pic_wr_t;

   localparam logic [2:0]  IDX_DONE   = 3'd5;
   localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
   localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
   localparam logic [7:0]  OCW2_EOI   = 8'h20;

   // Init list slots: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1 mask.
   function automatic pic_wr_t init_word(input logic [2:0] idx);
      pic_wr_t w;
      case (idx)
         3'd0:    w = '{a0: 1'b0, data: ICW1};
         3'd1:    w = '{a0: 1'b1, data: ICW2};
         3'd2:    w = '{a0: 1'b1, data: ICW3};
         3'd3:    w = '{a0: 1'b1, data: ICW4};
         default: w = '{a0: 1'b1, data: OCW1_MASK};
      endcase
      return w;
   endfunction

   function automatic logic [2:0] next_idx(input logic [2:0] idx);
      logic [2:0] n;
      case (idx)
         3'd0:    n = 3'd1;
         3'd1:    n = !ICW1[1] ? 3'd2 : (ICW1[0] ? 3'd3 : 3'd4);
         3'd2:    n = ICW1[0] ? 3'd3 : 3'd4;
         3'd3:    n = 3'd4;
         default: n = IDX_DONE;
      endcase
      return n;
   endfunction

   state_t      state, next_state;
   logic [15:0] cnt;
   logic [2:0]  wr_idx, idx_n;
   logic        wr_eoi, eoi_n;
   logic        launch_eoi;
   logic        eoi_pend;
   logic        int_q;
   logic        init_done_q;
   logic        vec_valid;
   logic [7:0]  vec_q;
   logic        cs_n, we_n, inta_n, a0_q;
   logic [7:0]  dout_q;
   pic_wr_t     wr_word;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_INIT;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      idx_n      = wr_idx;
      eoi_n      = wr_eoi;
      launch_eoi = 1'b0;
      case (state)
         S_INIT: begin
            next_state = S_WR_SETUP;
            idx_n      = 3'd0;
            eoi_n      = 1'b0;
         end
         S_WR_SETUP:  next_state = S_WR_STROBE;
         S_WR_STROBE: if (cnt == PULSE_LAST) next_state = S_WR_HOLD;
         S_WR_HOLD:   next_state = S_WR_GAP;
         S_WR_GAP: begin
            if (wr_eoi || next_idx(wr_idx) == IDX_DONE) begin
               next_state = S_IDLE;
            end else begin
               next_state = S_WR_SETUP;
               idx_n      = next_idx(wr_idx);
            end
         end
         // A pending EOI always wins over a new acknowledge cycle.
         S_IDLE: begin
            if (eoi_pend) begin
               next_state = S_WR_SETUP;
               eoi_n      = 1'b1;
               launch_eoi = 1'b1;
            end else if (init_done_q && !vec_valid && int_q) begin
               next_state = S_INTA1;
            end
         end
         S_INTA1:    if (cnt == PULSE_LAST) next_state = S_INTA_GAP;
         S_INTA_GAP: if (cnt == GAP_LAST)   next_state = S_INTA2;
         S_INTA2:    if (cnt == PULSE_LAST) next_state = S_VEC_HOLD;
         S_VEC_HOLD: next_state = S_IDLE;
         default:    next_state = S_INIT;
      endcase
   end

   assign wr_word = eoi_n ? '{a0: 1'b0, data: OCW2_EOI} : init_word(idx_n);

   // Pin strobes are registered off next_state so they change cleanly on the edge.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         wr_idx      <= '0;
         wr_eoi      <= 1'b0;
         eoi_pend    <= 1'b0;
         int_q       <= 1'b0;
         init_done_q <= 1'b0;
         vec_valid   <= 1'b0;
         vec_q       <= '0;
         cs_n        <= 1'b1;
         we_n        <= 1'b1;
         inta_n      <= 1'b1;
         a0_q        <= 1'b0;
         dout_q      <= '0;
      end else begin
         cnt         <= (next_state != state) ? '0 : cnt + 16'd1;
         wr_idx      <= idx_n;
         wr_eoi      <= eoi_n;
         int_q       <= bus.interrupt_to_cpu;
         eoi_pend    <= launch_eoi ? 1'b0 : (eoi_pend | bus.eoi_request);
         init_done_q <= init_done_q | (next_state == S_IDLE);
         cs_n        <= !(next_state inside {S_WR_SETUP, S_WR_STROBE, S_WR_HOLD});
         we_n        <= (next_state != S_WR_STROBE);
         inta_n      <= !(next_state inside {S_INTA1, S_INTA2});
         if (next_state == S_WR_SETUP && state != S_WR_SETUP) begin
            a0_q   <= wr_word.a0;
            dout_q <= wr_word.data;
         end
         if (state == S_INTA2 && next_state == S_VEC_HOLD) begin
            vec_q     <= bus.data_bus_in;
            vec_valid <= 1'b1;
         end else if (vec_valid && bus.vector_ready) begin
            vec_valid <= 1'b0;
         end
      end
   end

   assign bus.chip_select_n           = cs_n;
   assign bus.write_enable_n          = we_n;
   assign bus.address                 = {7'b0, a0_q};
   assign bus.data_bus_out            = dout_q;
   assign bus.interrupt_acknowledge_n = inta_n;
   assign bus.init_done               = init_done_q;
   assign bus.vector_valid            = vec_valid;
   assign bus.vector_data             = vec_q;
   assign bus.busy                    = (state != S_IDLE);

endmodule
